// File: rtl/rf_writeback_queue.sv
// Buffered writeback queue in front of the register file write port.
// Holds pending writes in a circular FIFO and bypasses them to lookups.
module rf_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain_en,
    input  logic              flush,
    output logic              WriteReg,
    output logic [ADDR_W-1:0] DstReg,
    output logic [DATA_W-1:0] DstData,
    input  logic [ADDR_W-1:0] lk_reg1,
    input  logic [ADDR_W-1:0] lk_reg2,
    output logic              lk_hit1,
    output logic              lk_hit2,
    output logic [DATA_W-1:0] lk_data1,
    output logic [DATA_W-1:0] lk_data2,
    output logic [CW-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] r_reg  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full && !flush;
    // Requests to R0 complete the handshake but are never stored.
    assign w_push   = in_valid && in_ready && (in_reg != '0);
    assign w_pop    = !w_empty && drain_en && !flush;

    assign WriteReg = w_pop;
    assign DstReg   = w_empty ? '0 : r_reg[r_head];
    assign DstData  = w_empty ? '0 : r_data[r_head];
    assign count    = r_count;

    // Pointer and occupancy bookkeeping; flush overrides push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Entry storage written at the tail slot on each accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_reg[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (w_push && !flush) begin
            r_reg[r_tail]  <= in_reg;
            r_data[r_tail] <= in_data;
        end
    end

    // Lookups scan oldest to youngest so the youngest match is kept last.
    always_comb begin
        logic [PW-1:0] w_idx;
        lk_hit1  = 1'b0;
        lk_hit2  = 1'b0;
        lk_data1 = '0;
        lk_data2 = '0;
        w_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (CW'(k) < r_count) begin
                if (lk_reg1 != '0 && r_reg[w_idx] == lk_reg1) begin
                    lk_hit1  = 1'b1;
                    lk_data1 = r_data[w_idx];
                end
                if (lk_reg2 != '0 && r_reg[w_idx] == lk_reg2) begin
                    lk_hit2  = 1'b1;
                    lk_data2 = r_data[w_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue: vector table,
// directed corner sequences and random traffic against a queue model.
`timescale 1ns/1ps
module tb_rf_writeback_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_reg;
    logic [15:0] in_data;
    logic        drain_en;
    logic        flush;
    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic [3:0]  lk_reg1;
    logic [3:0]  lk_reg2;
    logic        lk_hit1;
    logic        lk_hit2;
    logic [15:0] lk_data1;
    logic [15:0] lk_data2;
    logic [2:0]  count;

    rf_writeback_queue #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data),
        .drain_en(drain_en), .flush(flush),
        .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
        .lk_reg1(lk_reg1), .lk_reg2(lk_reg2),
        .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
        .lk_data1(lk_data1), .lk_data2(lk_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t q[$];

    typedef struct {
        logic v; logic [3:0] r; logic [15:0] d;
        logic dr; logic fl; logic [3:0] l1; logic [3:0] l2;
        logic e_rdy; logic e_wr; logic [3:0] e_dr; logic [15:0] e_dd;
        logic [2:0] e_cnt;
        logic e_h1; logic [15:0] e_d1; logic e_h2; logic [15:0] e_d2;
    } vec_t;

    vec_t vec[16];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] mlook(input logic [3:0] key);
        logic [16:0] res;
        res = '0;
        if (key != 0) begin
            foreach (q[i]) begin
                if (q[i].r == key) res = {1'b1, q[i].d};
            end
        end
        return res;
    endfunction

    task automatic drive(input logic v, input logic [3:0] r, input logic [15:0] d,
                         input logic dr, input logic fl,
                         input logic [3:0] l1, input logic [3:0] l2);
        in_valid = v; in_reg = r; in_data = d;
        drain_en = dr; flush = fl; lk_reg1 = l1; lk_reg2 = l2;
    endtask

    task automatic chk_model();
        logic [16:0] m1;
        logic [16:0] m2;
        int sz;
        sz = q.size();
        m1 = mlook(lk_reg1);
        m2 = mlook(lk_reg2);
        chk("ready", in_ready, (sz < DEPTH) && !flush);
        chk("wr", WriteReg, (sz != 0) && drain_en && !flush);
        chk("dstreg", DstReg, sz != 0 ? q[0].r : 4'd0);
        chk("dstdata", DstData, sz != 0 ? q[0].d : 16'd0);
        chk("count", count, sz);
        chk("lk1", {lk_hit1, lk_data1}, m1);
        chk("lk2", {lk_hit2, lk_data2}, m2);
    endtask

    task automatic commit();
        logic rdy;
        logic pop;
        @(posedge clk);
        rdy = (q.size() < DEPTH) && !flush;
        pop = (q.size() != 0) && drain_en && !flush;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (in_valid && rdy && in_reg != 0) q.push_back({in_reg, in_data});
        end
        #1;
    endtask

    task automatic step(input logic v, input logic [3:0] r, input logic [15:0] d,
                        input logic dr, input logic fl,
                        input logic [3:0] l1, input logic [3:0] l2);
        drive(v, r, d, dr, fl, l1, l2);
        @(negedge clk);
        chk_model();
        commit();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 1, 0, 3, 0);

        vec[0]  = '{0,0,16'h0,0,0,0,0,      1,0,0,16'h0,0,      0,16'h0,0,16'h0};
        vec[1]  = '{1,3,16'h1234,0,0,3,0,   1,0,0,16'h0,0,      0,16'h0,0,16'h0};
        vec[2]  = '{1,5,16'hBEEF,0,0,3,5,   1,0,3,16'h1234,1,   1,16'h1234,0,16'h0};
        vec[3]  = '{0,0,16'h0,0,0,5,3,      1,0,3,16'h1234,2,   1,16'hBEEF,1,16'h1234};
        vec[4]  = '{0,0,16'h0,1,0,3,5,      1,1,3,16'h1234,2,   1,16'h1234,1,16'hBEEF};
        vec[5]  = '{0,0,16'h0,1,0,3,5,      1,1,5,16'hBEEF,1,   0,16'h0,1,16'hBEEF};
        vec[6]  = '{0,0,16'h0,1,0,5,3,      1,0,0,16'h0,0,      0,16'h0,0,16'h0};
        vec[7]  = '{1,7,16'h0001,0,0,0,7,   1,0,0,16'h0,0,      0,16'h0,0,16'h0};
        vec[8]  = '{1,7,16'h0002,0,0,0,7,   1,0,7,16'h0001,1,   0,16'h0,1,16'h0001};
        vec[9]  = '{0,0,16'h0,0,0,0,7,      1,0,7,16'h0001,2,   0,16'h0,1,16'h0002};
        vec[10] = '{0,0,16'h0,1,0,0,7,      1,1,7,16'h0001,2,   0,16'h0,1,16'h0002};
        vec[11] = '{0,0,16'h0,1,0,0,7,      1,1,7,16'h0002,1,   0,16'h0,1,16'h0002};
        vec[12] = '{1,0,16'hFFFF,1,0,0,7,   1,0,0,16'h0,0,      0,16'h0,0,16'h0};
        vec[13] = '{0,0,16'h0,1,0,0,0,      1,0,0,16'h0,0,      0,16'h0,0,16'h0};
        vec[14] = '{1,9,16'h5555,0,1,9,0,   0,0,0,16'h0,0,      0,16'h0,0,16'h0};
        vec[15] = '{0,0,16'h0,0,0,9,0,      1,0,0,16'h0,0,      0,16'h0,0,16'h0};

        #12;
        chk("rst_count", count, 0);
        chk("rst_wr", WriteReg, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_dst", {DstReg, DstData}, 0);
        chk("rst_lk", {lk_hit1, lk_data1, lk_hit2, lk_data2}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            drive(vec[i].v, vec[i].r, vec[i].d, vec[i].dr, vec[i].fl,
                  vec[i].l1, vec[i].l2);
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), in_ready, vec[i].e_rdy);
            chk($sformatf("v%0d_wr", i), WriteReg, vec[i].e_wr);
            chk($sformatf("v%0d_dst", i), {DstReg, DstData},
                {vec[i].e_dr, vec[i].e_dd});
            chk($sformatf("v%0d_count", i), count, vec[i].e_cnt);
            chk($sformatf("v%0d_lk1", i), {lk_hit1, lk_data1},
                {vec[i].e_h1, vec[i].e_d1});
            chk($sformatf("v%0d_lk2", i), {lk_hit2, lk_data2},
                {vec[i].e_h2, vec[i].e_d2});
            commit();
        end

        // Fill to full, 5th request stalls, then drain and stream.
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 16'(16'h100 + i), 0, 0, 4'(i), 1);
        drive(1, 6, 16'h0606, 0, 0, 6, 4);
        @(negedge clk);
        chk("full_count", count, 4);
        chk("full_ready", in_ready, 0);
        chk_model();
        commit();
        drive(1, 6, 16'h0606, 1, 0, 6, 1);
        @(negedge clk);
        chk("full_pop_ready", in_ready, 0);
        chk("full_pop_wr", WriteReg, 1);
        chk_model();
        commit();
        chk("after_pop_ready", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            drive(1, 4'(1 + i % 15), 16'(16'hA000 + i), 1, 0, 4'(1 + i % 15), 6);
            @(negedge clk);
            chk_model();
            chk("pp_count", count, 3);
            commit();
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 1, 2);

        // Flush with a concurrent request.
        for (int i = 0; i < 3; i++) step(1, 4'(10 + i), 16'(16'hC000 + i), 0, 0, 10, 11);
        drive(1, 13, 16'hDDDD, 1, 1, 13, 10);
        @(negedge clk);
        chk("flush_ready", in_ready, 0);
        chk("flush_wr", WriteReg, 0);
        chk_model();
        commit();
        chk("flush_count", count, 0);
        step(0, 0, 0, 1, 0, 13, 10);

        // Asynchronous reset mid-drain.
        step(1, 2, 16'h2222, 0, 0, 2, 0);
        step(1, 8, 16'h8888, 0, 0, 2, 8);
        drive(0, 0, 0, 1, 0, 2, 8);
        @(negedge clk);
        chk("pre_rst_wr", WriteReg, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr", WriteReg, 0);
        chk("arst_count", count, 0);
        chk("arst_lk", {lk_hit1, lk_hit2}, 0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 1; i < 16; i++) begin
            drive(0, 0, 0, 0, 0, 4'(i), 4'(16 - i));
            @(negedge clk);
            chk("post_rst_hit", {lk_hit1, lk_hit2}, 0);
            commit();
        end

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 5)),
                 16'($urandom), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0,
                 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_writeback_queue.md
# rf_writeback_queue

Buffered writeback front-end for the 16-entry, 16-bit register file. It accepts register-write requests from the execute/memory side over a valid/ready handshake and holds them in a DEPTH-entry FIFO. It issues at most one write per cycle on the register file's write port (WriteReg/DstReg/DstData) whenever the port is allowed. It also gives two read-side lookup ports that return the youngest pending data for a register, so that source-operand reads can bypass writes that have not yet retired.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- DATA_W, 16, data width
- ADDR_W, 4, register-id width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has a writeback request
- in_ready  out  1  queue can accept a request this cycle
- in_reg  in  ADDR_W  destination register id
- in_data  in  DATA_W  write data
- drain_en  in  1  register file write port is available this cycle
- flush  in  1  synchronous discard of all pending entries
- WriteReg  out  1  write strobe to the register file
- DstReg  out  ADDR_W  write register id
- DstData  out  DATA_W  write data
- lk_reg1, lk_reg2  in  ADDR_W  lookup register ids (SrcReg1/SrcReg2)
- lk_hit1, lk_hit2  out  1  a pending entry matches
- lk_data1, lk_data2  out  DATA_W  youngest matching pending data; 0 on a miss
- count  out  clog2(DEPTH+1)  number of valid entries

## Operation
- Storage is a circular FIFO with a head pointer, a tail pointer and an occupancy count.
- in_ready = (count != DEPTH) and not flush. Full blocks input, even when a pop happens in the same cycle. There is no pass-through.
- Push happens when in_valid and in_ready and in_reg != 0. A request to R0 is accepted (handshake completes) and discarded. R0 is never written.
- WriteReg = (count != 0) and drain_en and not flush.
- DstReg and DstData come from the head entry when count != 0. When the queue is empty they are 0.
- Pop happens when WriteReg is 1.
- Push and pop may occur in the same cycle. In that case count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Same-register ordering is preserved. Multiple pending writes to one register retire oldest-first.
- Lookups are combinational over valid entries only. The youngest match wins.
  - A lookup of register 0 never hits.
  - The entry being popped this cycle still counts as a hit. The register file captures it at the same edge.
  - The current in_* request is not visible to lookups until it has been pushed.
- flush has priority over push and pop. At the edge it sets count to 0 and head = tail = 0. While flush is high, WriteReg = 0 and in_ready = 0.
- No state machine beyond the FIFO.
- Arithmetic: count updates as +1 on push only, -1 on pop only, and no change otherwise. It never underflows or overflows, because push is gated by full and pop is gated by empty.

## Timing
- Reset (asynchronous, immediate) values:
  - count = 0, pointers = 0, all entries invalid
  - WriteReg = 0, DstReg = 0, DstData = 0
  - lk_hit1/2 = 0, lk_data1/2 = 0
  - in_ready = 1 (provided flush = 0)
- Latency: a request pushed at edge N is visible on the lookup ports and at the head (if the queue was empty) from edge N through the cycle before edge N+1. With drain_en high it is written to the register file at edge N+1. The minimum push-to-retire time is 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- drain_en low holds the head. The outputs stay stable and WriteReg = 0.
- When rst asserts mid-operation, all pending writes are lost. No write strobe is issued during reset.

## Test plan
- Reset, then with drain_en=0 push (R3,0x1234), (R5,0xBEEF) -> count=2; lk_reg1=5 gives hit=1, data=0xBEEF; WriteReg=0. Raise drain_en -> WriteReg pulses for exactly 2 cycles, with DstReg 3 then 5, then count=0.
- With drain_en=0 push (R7,0x0001) then (R7,0x0002) -> lk_reg2=7 gives 0x0002. Drain -> writes retire in order: 0x0001, then 0x0002.
- Fill to DEPTH=4 with drain_en=0 -> in_ready=0 and a 5th request stalls. Raise drain_en -> in_ready=1 the next cycle. Then run continuous push+pop for 10 cycles -> count stays constant and pointers wrap correctly.
- Push (R0,0xFFFF) -> in_ready=1, count stays 0, WriteReg never asserts. lk_reg1=0 gives hit=0, data=0.
- Load 3 entries, assert flush while in_valid=1 -> after the edge count=0, no WriteReg, and the concurrent request is dropped (in_ready was 0).
- Assert rst asynchronously mid-drain with 2 entries pending -> WriteReg=0 immediately and count=0. After release, lookups all miss.
